hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It drives write-enables and flushes for the PC, IF/ID, ID/EX (IDEXE_RegWrite / IDFlush of the decode stage), EX/MEM and MEM/WB registers.
- Resolves load-use hazards by inserting one bubble.
- Applies taken-branch/jump redirects.
- Freezes the whole pipeline while instruction or data memory is busy.
- Holds a pending redirect across a freeze so that it is applied exactly once.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_perf_cnt.sv | 20 ++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = 5'd0;
    // Instruction loaded into IF/ID when it is flushed (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } hazard_state_e;

    // A load in EX whose rd feeds either source of the instruction in ID; x0 never hazards
    function automatic logic reg_hazard(input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] rs1,
                                        input logic [REG_W-1:0] rs2);
        return (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline status in / stage enable and flush out bundle
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] id_rs1addr;
    logic [REG_W-1:0] id_rs2addr;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rdaddr;
    logic             ex_branch_taken;
    logic             im_stall;
    logic             dm_stall;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_write;

    // Datapath side: reports hazards, consumes stage controls
    modport master (
        output id_rs1addr, id_rs2addr, ex_memread, ex_rdaddr,
               ex_branch_taken, im_stall, dm_stall,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_write
    );

    // Controller side
    modport slave (
        input  id_rs1addr, id_rs2addr, ex_memread, ex_rdaddr,
               ex_branch_taken, im_stall, dm_stall,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, memwb_write
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating event counter
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, sticking at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer; HAZARD_PERF_EN adds counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    hazard_state_e state, state_nxt;
    logic [3:0]    init_cnt, init_cnt_nxt;
    logic          redirect_pend, redirect_pend_nxt;

    logic mem_busy;
    logic load_use;
    logic redir;

    logic pc_write, ifid_write, ifid_flush;
    logic idex_write, idex_flush, exmem_write, memwb_write;
    logic stall_inc, bubble_inc, flush_inc;

    assign mem_busy = hz.im_stall | hz.dm_stall;
    assign load_use = hz.ex_memread & reg_hazard(hz.ex_rdaddr, hz.id_rs1addr, hz.id_rs2addr);
    // A redirect remembered from a freeze is replayed as if EX had just resolved it
    assign redir    = hz.ex_branch_taken | redirect_pend;

    // State, init counter and pending-redirect flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            init_cnt      <= '0;
            redirect_pend <= 1'b0;
        end else begin
            state         <= state_nxt;
            init_cnt      <= init_cnt_nxt;
            redirect_pend <= redirect_pend_nxt;
        end
    end

    // Next state and stage controls decoded from state, pending redirect and hazard inputs
    always_comb begin
        state_nxt         = state;
        init_cnt_nxt      = init_cnt;
        redirect_pend_nxt = redirect_pend;
        pc_write          = 1'b0;
        ifid_write        = 1'b0;
        ifid_flush        = 1'b0;
        idex_write        = 1'b0;
        idex_flush        = 1'b0;
        exmem_write       = 1'b0;
        memwb_write       = 1'b0;
        stall_inc         = 1'b0;
        bubble_inc        = 1'b0;
        flush_inc         = 1'b0;

        case (state)
            INIT: begin
                init_cnt_nxt = init_cnt + 4'd1;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (mem_busy) begin
                    // Freeze starts this very cycle; nothing moves, a redirect waits
                    state_nxt = FREEZE;
                    stall_inc = 1'b1;
                    if (hz.ex_branch_taken) begin
                        redirect_pend_nxt = 1'b1;
                    end
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    idex_write  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                    if (redir) begin
                        // Squash the two wrong-path instructions; counts once even if both sources are set
                        ifid_flush        = 1'b1;
                        idex_flush        = 1'b1;
                        redirect_pend_nxt = 1'b0;
                        flush_inc         = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, send a bubble into EX; the load moves on so this lasts one cycle
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        bubble_inc = 1'b1;
                    end
                end
            end

            FREEZE: begin
                stall_inc = 1'b1;
                if (hz.ex_branch_taken) begin
                    redirect_pend_nxt = 1'b1;
                end
                // Resume next cycle so any pending redirect is applied exactly once in RUN
                if (!mem_busy) begin
                    state_nxt = RUN;
                end
            end

            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_write  = idex_write;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_write = exmem_write;
    assign hz.memwb_write = memwb_write;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf  = stall_inc ^ bubble_inc ^ flush_inc;
    assign stall_cycles = '0;
    assign bubble_cnt   = '0;
    assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_write}
    localparam logic [6:0] O_ZERO = 7'b000_0000;
    localparam logic [6:0] O_RUN  = 7'b110_1011;
    localparam logic [6:0] O_BUB  = 7'b000_1111;
    localparam logic [6:0] O_RED  = 7'b111_1111;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       im;
        logic       dm;
        logic [6:0] exp;
        logic       frz;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();
    logic [CNT_W-1:0] stall_cycles, bubble_cnt, flush_cnt;

    hazard_ctrl #(.INIT_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hz),
        .stall_cycles (stall_cycles),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    wire [6:0] outs = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write,
                       hz.idex_flush, hz.exmem_write, hz.memwb_write};

    int vectors = 0;
    int errors  = 0;
    logic [6:0] sb[$];
    int m_stall = 0, m_bub = 0, m_flush = 0;

    function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic mr, input logic [4:0] rd, input logic br,
                                input logic im, input logic dm, input logic [6:0] exp,
                                input logic frz);
        vec_t v;
        v = '{rst, rs1, rs2, mr, rd, br, im, dm, exp, frz};
        return v;
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic int exp_cnt(input int m);
`ifdef HAZARD_PERF_EN
        return m;
`else
        return 0;
`endif
    endfunction

    // Apply one cycle of stimulus and queue its expected controls; update the counter model
    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst_n              = v.rst;
        hz.id_rs1addr      = v.rs1;
        hz.id_rs2addr      = v.rs2;
        hz.ex_memread      = v.mr;
        hz.ex_rdaddr       = v.rd;
        hz.ex_branch_taken = v.br;
        hz.im_stall        = v.im;
        hz.dm_stall        = v.dm;
        sb.push_back(v.exp);
        if (!v.rst) begin
            m_stall = 0; m_bub = 0; m_flush = 0;
        end else begin
            if (v.frz)          m_stall = sat(m_stall + 1);
            if (v.exp == O_BUB) m_bub   = sat(m_bub + 1);
            if (v.exp == O_RED) m_flush = sat(m_flush + 1);
        end
    endtask

    task automatic test_reset();
        vec_t v[$];
        logic [6:0] e;
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (outs !== e) begin
                errors++;
                $display("FAIL reset step %0d: controls got %b want %b", i, outs, e);
            end
        end
        vectors++;
        if ({stall_cycles, bubble_cnt, flush_cnt} !== {3*CNT_W{1'b0}}) begin
            errors++;
            $display("FAIL reset counters: got %h/%h/%h want 0/0/0", stall_cycles, bubble_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        logic [6:0] e;
        v.push_back(mk(1, 3, 5, 1, 5, 0, 0, 0, O_BUB, 0));
        v.push_back(mk(1, 3, 5, 0, 5, 0, 0, 0, O_RUN, 0));
        v.push_back(mk(1, 7, 1, 1, 7, 0, 0, 0, O_BUB, 0));
        v.push_back(mk(1, 7, 1, 0, 7, 0, 0, 0, O_RUN, 0));
        v.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, O_RUN, 0));
        v.push_back(mk(1, 8, 10, 1, 9, 0, 0, 0, O_RUN, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (outs !== e) begin
                errors++;
                $display("FAIL load_use step %0d: controls got %b want %b", i, outs, e);
            end
        end
        vectors++;
        if (int'(bubble_cnt) !== exp_cnt(m_bub)) begin
            errors++;
            $display("FAIL load_use bubble_cnt: got %0d want %0d", bubble_cnt, exp_cnt(m_bub));
        end
    endtask

    task automatic test_redirect();
        vec_t v[$];
        logic [6:0] e;
        v.push_back(mk(1, 3, 5, 1, 5, 1, 0, 0, O_RED, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, O_RED, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, O_RED, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (outs !== e) begin
                errors++;
                $display("FAIL redirect step %0d: controls got %b want %b", i, outs, e);
            end
        end
        vectors++;
        if ({int'(flush_cnt), int'(bubble_cnt)} !== {exp_cnt(m_flush), exp_cnt(m_bub)}) begin
            errors++;
            $display("FAIL redirect counters: flush/bubble got %0d/%0d want %0d/%0d",
                     flush_cnt, bubble_cnt, exp_cnt(m_flush), exp_cnt(m_bub));
        end
    endtask

    task automatic test_freeze_redirect();
        vec_t v[$];
        logic [6:0] e;
        int s0;
        s0 = m_stall;
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 1));
        v.push_back(mk(1, 3, 5, 1, 5, 0, 0, 0, O_RED,  0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        // Branch held through the freeze and into the apply cycle: still one redirect
        v.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, O_RED,  0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (outs !== e) begin
                errors++;
                $display("FAIL freeze step %0d: controls got %b want %b", i, outs, e);
            end
        end
        vectors++;
        if ({int'(stall_cycles), int'(flush_cnt)} !== {exp_cnt(m_stall), exp_cnt(m_flush)}) begin
            errors++;
            $display("FAIL freeze counters: stall/flush got %0d/%0d want %0d/%0d (stall start %0d)",
                     stall_cycles, flush_cnt, exp_cnt(m_stall), exp_cnt(m_flush), s0);
        end
    endtask

    task automatic test_reset_mid_freeze();
        vec_t v[$];
        logic [6:0] e;
        v.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, O_ZERO, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_ZERO, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (outs !== e) begin
                errors++;
                $display("FAIL reset_mid_freeze step %0d: controls got %b want %b", i, outs, e);
            end
        end
        vectors++;
        if ({stall_cycles, bubble_cnt, flush_cnt} !== {3*CNT_W{1'b0}}) begin
            errors++;
            $display("FAIL reset_mid_freeze counters: got %h/%h/%h want 0/0/0",
                     stall_cycles, bubble_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        vec_t v[$];
        logic [6:0] e;
        for (int k = 0; k < 20; k++) v.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 1));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (outs !== e) begin
                errors++;
                $display("FAIL saturation step %0d: controls got %b want %b", i, outs, e);
            end
        end
        vectors++;
        if (int'(stall_cycles) !== exp_cnt(m_stall)) begin
            errors++;
            $display("FAIL saturation stall_cycles: got %0d want %0d", stall_cycles, exp_cnt(m_stall));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hz.id_rs1addr      = '0;
        hz.id_rs2addr      = '0;
        hz.ex_memread      = 1'b0;
        hz.ex_rdaddr       = '0;
        hz.ex_branch_taken = 1'b0;
        hz.im_stall        = 1'b0;
        hz.dm_stall        = 1'b0;
        test_reset();
        test_load_use();
        test_redirect();
        test_freeze_redirect();
        test_reset_mid_freeze();
        test_saturation();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
